// File: rtl/word_descrambler.sv
// rtl/word_descrambler.sv - two-stage streaming descrambler: per-word invert mask, then keyed bit-pair swap.
module word_descrambler #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               keyLoad,
  input  logic [WIDTH/2-1:0] swapKeyIn,
  input  logic [WIDTH-1:0]   invertKeyIn,
  input  logic               bypass,
  input  logic               inValid,
  output logic               inReady,
  input  logic [WIDTH-1:0]   inData,
  output logic               outValid,
  input  logic               outReady,
  output logic [WIDTH-1:0]   outData,
  output logic [WIDTH-1:0]   wordCount
);

  localparam int HALF = WIDTH / 2;

  logic [HALF-1:0]  swapKey;
  logic [WIDTH-1:0] invertKey;
  logic [WIDTH-1:0] counter;

  logic             aValid;
  logic [WIDTH-1:0] aData;
  logic [HALF-1:0]  aSwap;
  logic             bValid;
  logic [WIDTH-1:0] bData;

  logic             aReady;
  logic             bReady;
  logic             accept;
  logic [WIDTH-1:0] swapped;

  assign bReady  = !bValid || outReady;
  assign aReady  = !aValid || bReady;
  assign inReady = aReady;
  assign accept  = inValid && aReady;

  always_comb begin
    swapped = aData;
    for (int i = 0; i < HALF; i++) begin
      if (aSwap[i]) begin
        swapped[2*i]   = aData[2*i+1];
        swapped[2*i+1] = aData[2*i];
      end
    end
  end

  // Load takes priority; the word accepted on the same edge already used the old keys.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      swapKey   <= '0;
      invertKey <= '0;
      counter   <= '0;
    end else if (keyLoad) begin
      swapKey   <= swapKeyIn;
      invertKey <= invertKeyIn;
      counter   <= '0;
    end else if (accept) begin
      swapKey <= (swapKey << 1) | (swapKey >> (HALF - 1));
      counter <= counter + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      aValid <= 1'b0;
      aData  <= '0;
      aSwap  <= '0;
    end else if (aReady) begin
      aValid <= accept;
      if (accept) begin
        aData <= bypass ? inData : (inData ^ invertKey ^ counter);
        aSwap <= bypass ? '0 : swapKey;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      bValid <= 1'b0;
      bData  <= '0;
    end else if (bReady) begin
      bValid <= aValid;
      if (aValid) begin
        bData <= swapped;
      end
    end
  end

  assign outValid  = bValid;
  assign outData   = bData;
  assign wordCount = counter;

endmodule

// File: tb/tb_word_descrambler.sv
// tb/tb_word_descrambler.sv - randomized and directed bench for word_descrambler with an in-bench reference model.
module tb_word_descrambler;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        keyLoad = 1'b0;
  logic [7:0]  swapKeyIn = '0;
  logic [15:0] invertKeyIn = '0;
  logic        bypass = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] inData = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] outData;
  logic [15:0] wordCount;

  word_descrambler #(.WIDTH(16)) dut (
    .clk(clk), .nReset(nReset), .keyLoad(keyLoad), .swapKeyIn(swapKeyIn),
    .invertKeyIn(invertKeyIn), .bypass(bypass), .inValid(inValid), .inReady(inReady),
    .inData(inData), .outValid(outValid), .outReady(outReady), .outData(outData),
    .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: key state plus the ordered list of words inside the pipe.
  logic [7:0]  mSwap = '0;
  logic [15:0] mInv = '0;
  logic [15:0] mCnt = '0;
  logic [15:0] pipeQ[$];
  logic [15:0] got[$];
  bit          justAcc = 0;
  bit          logOn = 0;

  function automatic logic [15:0] expect_word(input logic [15:0] d, input logic [7:0] sw,
                                              input logic [15:0] inv, input logic [15:0] cnt,
                                              input logic byp);
    logic [15:0] x;
    logic [15:0] y;
    if (byp) return d;
    x = d ^ inv ^ cnt;
    y = x;
    for (int i = 0; i < 8; i++) begin
      if (sw[i]) begin
        y[2*i]   = x[2*i+1];
        y[2*i+1] = x[2*i];
      end
    end
    return y;
  endfunction

  always @(negedge clk) begin
    bit acc;
    logic [15:0] exp;
    if (!nReset) begin
      pipeQ.delete();
      justAcc = 0;
      mSwap = '0;
      mInv = '0;
      mCnt = '0;
    end else begin
      chk("inReady", {31'd0, inReady}, {31'd0, (pipeQ.size() < 2) || outReady});
      chk("outValid", {31'd0, outValid},
          {31'd0, (pipeQ.size() >= 2) || (pipeQ.size() == 1 && !justAcc)});
      chk("wordCount", {16'd0, wordCount}, {16'd0, mCnt});
      if (outValid && pipeQ.size() > 0) chk("outData", {16'd0, outData}, {16'd0, pipeQ[0]});
      if (outValid && outReady) begin
        if (pipeQ.size() == 0) chk("underflow", 32'd1, 32'd0);
        else exp = pipeQ.pop_front();
        if (logOn) got.push_back(outData);
      end
      acc = inValid && inReady;
      if (acc) pipeQ.push_back(expect_word(inData, mSwap, mInv, mCnt, bypass));
      justAcc = acc;
      if (keyLoad) begin
        mSwap = swapKeyIn;
        mInv = invertKeyIn;
        mCnt = '0;
      end else if (acc) begin
        mSwap = {mSwap[6:0], mSwap[7]};
        mCnt = mCnt + 16'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic kl);
    int n;
    inValid = 1'b1;
    inData = d;
    keyLoad = kl;
    n = 0;
    @(negedge clk);
    while (!inReady && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    step();
    inValid = 1'b0;
    keyLoad = 1'b0;
  endtask

  task automatic load_keys(input logic [7:0] s, input logic [15:0] v);
    swapKeyIn = s;
    invertKeyIn = v;
    keyLoad = 1'b1;
    step();
    keyLoad = 1'b0;
  endtask

  task automatic drain();
    outReady = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    repeat (2) step();
    nReset = 1'b1;
    @(negedge clk);
    chk("rst_outData", {16'd0, outData}, 32'd0);
    chk("rst_inReady", {31'd0, inReady}, 32'd1);
    step();

    // Basic stream with zero keys.
    outReady = 1'b1;
    logOn = 1;
    got.delete();
    send(16'h1234, 1'b0);
    send(16'hABCD, 1'b0);
    drain();
    chk("t1_w0", {16'd0, got[0]}, 32'h1234);
    chk("t1_w1", {16'd0, got[1]}, 32'hABCC);
    @(negedge clk);
    chk("t1_count", {16'd0, wordCount}, 32'd2);
    step();

    // Swap key rotation.
    load_keys(8'h01, 16'h0000);
    got.delete();
    send(16'h0001, 1'b0);
    send(16'h0004, 1'b0);
    drain();
    chk("t2_w0", {16'd0, got[0]}, 32'h0002);
    chk("t2_w1", {16'd0, got[1]}, 32'h0009);

    // Stall with three words.
    load_keys(8'h00, 16'h0000);
    got.delete();
    outReady = 1'b0;
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    inValid = 1'b1;
    inData = 16'h3333;
    repeat (3) begin
      @(negedge clk);
      chk("t3_inReady_low", {31'd0, inReady}, 32'd0);
      chk("t3_hold", {16'd0, outData}, 32'h1111);
    end
    step();
    outReady = 1'b1;
    send(16'h3333, 1'b0);
    drain();
    chk("t3_n", got.size(), 32'd3);
    chk("t3_w0", {16'd0, got[0]}, 32'h1111);
    chk("t3_w1", {16'd0, got[1]}, 32'h2223);
    chk("t3_w2", {16'd0, got[2]}, 32'h3331);

    // Key load coinciding with an accept.
    got.delete();
    swapKeyIn = 8'h01;
    invertKeyIn = 16'hFF00;
    send(16'h00F0, 1'b1);
    @(negedge clk);
    chk("t4_count", {16'd0, wordCount}, 32'd0);
    step();
    send(16'h0001, 1'b0);
    drain();
    chk("t4_w0", {16'd0, got[0]}, 32'h00F3);
    chk("t4_w1", {16'd0, got[1]}, 32'hFF02);
    logOn = 0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      inValid = ($urandom % 4) != 0;
      inData = 16'($urandom);
      outReady = ($urandom % 4) != 0;
      keyLoad = ($urandom % 20) == 0;
      swapKeyIn = 8'($urandom);
      invertKeyIn = 16'($urandom);
      bypass = ($urandom % 8) == 0;
      step();
    end
    inValid = 1'b0;
    keyLoad = 1'b0;
    bypass = 1'b0;
    drain();

    // Counter wrap at full throughput.
    load_keys(8'h00, 16'h0000);
    outReady = 1'b1;
    inValid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      inData = 16'($urandom);
      step();
    end
    inValid = 1'b0;
    drain();
    @(negedge clk);
    chk("t6_count", {16'd0, wordCount}, 32'hFFFF);
    step();
    logOn = 1;
    got.delete();
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    drain();
    chk("t6_w0", {16'd0, got[0]}, 32'hFFFF);
    chk("t6_w1", {16'd0, got[1]}, 32'h0000);

    // Reset with both stages full.
    load_keys(8'h5A, 16'h1357);
    outReady = 1'b0;
    send(16'hAAAA, 1'b0);
    send(16'h5555, 1'b0);
    @(posedge clk);
    #2;
    nReset = 1'b0;
    #1;
    chk("t7_outValid", {31'd0, outValid}, 32'd0);
    chk("t7_outData", {16'd0, outData}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    outReady = 1'b1;
    got.delete();
    repeat (3) step();
    @(negedge clk);
    chk("t7_count", {16'd0, wordCount}, 32'd0);
    step();
    send(16'h1234, 1'b0);
    drain();
    chk("t7_n", got.size(), 32'd1);
    chk("t7_w0", {16'd0, got[0]}, 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
